// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage: multi-cycle MULT/MULTU/DIV/DIVU,
// single-cycle MTHI/MTLO, and the architectural HI/LO registers.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        o_dbg_state
);

  // Handshake: start is a one-cycle request qualified only by busy==0;
  // a start presented while busy is high (including the completion cycle)
  // is dropped, never queued.

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_op;
  logic [31:0]      r_rs;
  logic [31:0]      r_rt;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic             r_busy;

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_div_signed;
  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;
  logic        w_res_we;

  assign w_prod_s = $signed({{32{r_rs[31]}}, r_rs}) * $signed({{32{r_rt[31]}}, r_rt});
  assign w_prod_u = {32'd0, r_rs} * {32'd0, r_rt};

  // Signed divide runs on magnitudes; 0x80000000/-1 falls out as 0x80000000.
  assign w_div_signed = (r_op == OP_DIV);
  assign w_neg_a      = w_div_signed & r_rs[31];
  assign w_neg_b      = w_div_signed & r_rt[31];
  assign w_mag_a      = w_neg_a ? (32'd0 - r_rs) : r_rs;
  assign w_mag_b      = w_neg_b ? (32'd0 - r_rt) : r_rt;
  assign w_uq         = (w_mag_b == 32'd0) ? 32'd0 : (w_mag_a / w_mag_b);
  assign w_ur         = (w_mag_b == 32'd0) ? 32'd0 : (w_mag_a % w_mag_b);

  always_comb begin
    w_res_hi = r_hi;
    w_res_lo = r_lo;
    w_res_we = 1'b0;
    case (r_op)
      OP_MULT: begin
        w_res_hi = w_prod_s[63:32];
        w_res_lo = w_prod_s[31:0];
        w_res_we = 1'b1;
      end
      OP_MULTU: begin
        w_res_hi = w_prod_u[63:32];
        w_res_lo = w_prod_u[31:0];
        w_res_we = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        w_res_lo = (w_neg_a ^ w_neg_b) ? (32'd0 - w_uq) : w_uq;
        w_res_hi = w_neg_a ? (32'd0 - w_ur) : w_ur;
        w_res_we = (r_rt != 32'd0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= 3'd0;
      r_rs    <= 32'd0;
      r_rt    <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                r_op    <= op;
                r_rs    <= rs;
                r_rt    <= rt;
                r_cnt   <= CNT_W'(MULT_CYCLES);
                r_busy  <= 1'b1;
                r_state <= S_RUN;
              end
              OP_DIV, OP_DIVU: begin
                r_op    <= op;
                r_rs    <= rs;
                r_rt    <= rt;
                r_cnt   <= CNT_W'(DIV_CYCLES);
                r_busy  <= 1'b1;
                r_state <= S_RUN;
              end
              OP_MTHI: r_hi <= rs;
              OP_MTLO: r_lo <= rs;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            if (w_res_we) begin
              r_hi <= w_res_hi;
              r_lo <= w_res_lo;
            end
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases plus randomized ops
// checked against an arithmetic reference model of HI/LO.
module tb_md_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [63:0] exp_q[$];

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk         (clk),
    .reset       (rst_n),
    .start       (start),
    .op          (op),
    .rs          (rs),
    .rt          (rt),
    .busy        (busy),
    .hi          (hi),
    .lo          (lo),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: resulting {hi,lo} and busy length for one accepted op.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [63:0] res, output int len);
    longint          sa, sb, q, r;
    longint unsigned pu;
    res = {m_hi, m_lo};
    len = 0;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    case (o)
      3'd1: begin res = 64'(sa * sb); len = MULT_N; end
      3'd2: begin pu = 64'(a) * 64'(b); res = pu; len = MULT_N; end
      3'd3: begin
        len = DIV_N;
        if (b != 0) begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      3'd4: begin
        len = DIV_N;
        if (b != 0) res = {a % b, a / b};
      end
      3'd5: res = {a, m_lo};
      3'd6: res = {m_hi, a};
      default: ;
    endcase
  endtask

  // Present one start at the next negedge; operands are scrambled afterwards.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    rs    = a;
    rt    = b;
    @(negedge clk);
    start = 1'b0;
    op    = 3'd0;
    rs    = $urandom;
    rt    = $urandom;
  endtask

  // Count busy cycles at negedges, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
      rs = $urandom;
      rt = $urandom;
    end
  endtask

  task automatic run_md(input string tag, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] b);
    logic [63:0] res;
    logic [63:0] e;
    int          len;
    int          n;
    model(o, a, b, res, len);
    exp_q.push_back(res);
    issue(o, a, b);
    wait_idle(n);
    check({tag, "_busy_len"}, 64'(n), 64'(len));
    e = exp_q.pop_front();
    check({tag, "_hi"}, {32'd0, hi}, {32'd0, e[63:32]});
    check({tag, "_lo"}, {32'd0, lo}, {32'd0, e[31:0]});
    m_hi = hi;
    m_lo = lo;
    m_hi = e[63:32];
    m_lo = e[31:0];
  endtask

  initial begin
    int          n;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    rst_n = 1'b0;
    start = 1'b0;
    op    = 3'd0;
    rs    = 32'd0;
    rt    = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    rst_n = 1'b1;

    // Reset mid-operation
    run_md("pre_mthi", 3'd5, 32'hAAAA_0001, 32'd0);
    run_md("pre_mtlo", 3'd6, 32'hBBBB_0002, 32'd0);
    issue(3'd1, 32'd3, 32'd4);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_hi", {32'd0, hi}, 64'd0);
    check("midrst_lo", {32'd0, lo}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    rst_n = 1'b1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    repeat (12) @(negedge clk);
    check("postrst_hi", {32'd0, hi}, 64'd0);
    check("postrst_lo", {32'd0, lo}, 64'd0);
    check("postrst_busy", {63'd0, busy}, 64'd0);
    run_md("mtlo55", 3'd6, 32'h55, 32'd0);

    // Directed arithmetic
    run_md("mult_neg", 3'd1, 32'hFFFF_FFFE, 32'd3);
    check("mult_neg_hi_k", {32'd0, hi}, 64'hFFFF_FFFF);
    check("mult_neg_lo_k", {32'd0, lo}, 64'hFFFF_FFFA);
    run_md("multu", 3'd2, 32'hFFFF_FFFE, 32'd3);
    check("multu_hi_k", {32'd0, hi}, 64'h2);
    run_md("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2);
    check("div_neg_lo_k", {32'd0, lo}, 64'hFFFF_FFFD);
    check("div_neg_hi_k", {32'd0, hi}, 64'hFFFF_FFFF);
    run_md("divu", 3'd4, 32'd7, 32'd2);
    run_md("mthi11", 3'd5, 32'h11, 32'd0);
    run_md("mtlo22", 3'd6, 32'h22, 32'd0);
    run_md("div0", 3'd3, 32'd5, 32'd0);
    check("div0_hi_k", {32'd0, hi}, 64'h11);
    check("div0_lo_k", {32'd0, lo}, 64'h22);
    run_md("divu0", 3'd4, 32'd9, 32'd0);
    run_md("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_lo_k", {32'd0, lo}, 64'h8000_0000);
    run_md("nop0", 3'd0, 32'h1234, 32'h5678);
    run_md("nop7", 3'd7, 32'h1234, 32'h5678);

    // Starts during busy (cycles 2, 4 and the completion cycle) are dropped
    issue(3'd1, 32'd2, 32'd3);
    @(negedge clk);
    start = 1'b1; op = 3'd6; rs = 32'h99;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    @(negedge clk);
    start = 1'b1; op = 3'd3; rs = 32'd100; rt = 32'd7;
    @(negedge clk);
    start = 1'b1; op = 3'd5; rs = 32'h77;
    check("busy_c5", {63'd0, busy}, 64'd1);
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    check("busy_c6", {63'd0, busy}, 64'd0);
    check("sdb_lo", {32'd0, lo}, 64'd6);
    check("sdb_hi", {32'd0, hi}, 64'd0);
    wait_idle(n);
    check("sdb_no_restart", 64'(n), 64'd0);
    m_hi = 32'd0;
    m_lo = 32'd6;

    // Randomized ops
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 9));
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        default: ;
      endcase
      run_md($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
